msg_fifo_stream_reg: RTL and testbench

MSG_FIFO_STREAM_REG -- requirements
Module: msg_fifo_stream_reg

---
 rtl/msg_fifo_stream_reg_if.sv | 41 ++++
 rtl/msg_fifo_stream_reg.sv | 146 ++++++++++++++
 tb/tb_msg_fifo_stream_reg.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/msg_fifo_stream_reg_if.sv
// Bundles the message FIFO ports and the stream-register handshake.
// slave is the design side; master is the driver side.
interface msg_fifo_stream_reg_if #(
  parameter int DATA_WIDTH = 26,
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 256
);
  localparam int USEDW_WIDTH = $clog2(FIFO_DEPTH);

  // message FIFO
  logic [FIFO_WIDTH-1:0]  fifo_data;
  logic                   fifo_wrreq;
  logic                   fifo_rdreq;
  logic                   fifo_sclr;
  logic [FIFO_WIDTH-1:0]  fifo_q;
  logic [USEDW_WIDTH-1:0] fifo_usedw;
  logic                   fifo_empty;
  logic                   fifo_full;

  // stream register
  logic                   sr_valid_in;
  logic [DATA_WIDTH-1:0]  sr_data_in;
  logic                   sr_ready_out;
  logic                   sr_valid_out;
  logic [DATA_WIDTH-1:0]  sr_data_out;
  logic                   sr_ready_in;

  modport slave (
    input  fifo_data, fifo_wrreq, fifo_rdreq, fifo_sclr,
    output fifo_q, fifo_usedw, fifo_empty, fifo_full,
    input  sr_valid_in, sr_data_in, sr_ready_in,
    output sr_ready_out, sr_valid_out, sr_data_out
  );

  modport master (
    output fifo_data, fifo_wrreq, fifo_rdreq, fifo_sclr,
    input  fifo_q, fifo_usedw, fifo_empty, fifo_full,
    output sr_valid_in, sr_data_in, sr_ready_in,
    input  sr_ready_out, sr_valid_out, sr_data_out
  );
endinterface

// File: rtl/msg_fifo_stream_reg.sv
// Show-ahead message FIFO plus a 2-entry skid-buffered stream register.
// FIFO_DEPTH is expected to be a power of two so pointers wrap naturally.
module msg_fifo_stream_reg #(
  parameter int DATA_WIDTH = 26,
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 256
) (
  input  logic clk,
  input  logic rst,
  msg_fifo_stream_reg_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  // ---------------- message FIFO ----------------
  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic [FIFO_WIDTH-1:0] q_q, q_d;
  logic                  wr_en, rd_en;
  logic [AW-1:0]         rd_nxt;

  // A pop needs a stored word; a push is allowed when full only if a pop
  // frees a slot in the same cycle. Clear overrides both.
  assign rd_en  = bus.fifo_rdreq & ~empty_q & ~bus.fifo_sclr;
  assign wr_en  = bus.fifo_wrreq & (~full_q | rd_en) & ~bus.fifo_sclr;
  assign rd_nxt = rd_ptr_q + AW'(1);

  // Next pointers, count, flags and head word
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    if (bus.fifo_sclr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_nxt;
      case ({wr_en, rd_en})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
      // The head register tracks mem[rd_ptr]; when the slot behind the
      // head is being written this very cycle, bypass the write data.
      if (rd_en) begin
        if (cnt_q == (AW+1)'(1)) begin
          if (wr_en) q_d = bus.fifo_data;
        end else begin
          q_d = mem_q[rd_nxt];
        end
      end else if (wr_en && empty_q) begin
        q_d = bus.fifo_data;
      end
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == (AW+1)'(FIFO_DEPTH));
  end

  // FIFO control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      q_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      q_q      <= q_d;
    end
  end

  // Storage array; contents need no reset since the pointers guard them
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.fifo_data;
  end

  assign bus.fifo_q     = q_q;
  assign bus.fifo_usedw = cnt_q[AW-1:0];
  assign bus.fifo_empty = empty_q;
  assign bus.fifo_full  = full_q;

  // ---------------- stream register ----------------
  logic                  main_vld_q, main_vld_d;
  logic [DATA_WIDTH-1:0] main_dat_q, main_dat_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [DATA_WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic                  in_fire, out_fire;

  assign in_fire  = bus.sr_valid_in & ~skid_vld_q;
  assign out_fire = main_vld_q & bus.sr_ready_in;

  // Main register refills from skid first, then from upstream; an accept
  // while main is stalled parks the word in skid.
  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (!main_vld_q || out_fire) begin
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_dat_d = skid_dat_q;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        main_vld_d = 1'b1;
        main_dat_d = bus.sr_data_in;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_vld_d = 1'b1;
      skid_dat_d = bus.sr_data_in;
    end
  end

  // Stream register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      main_dat_q <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      main_dat_q <= main_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end

  assign bus.sr_valid_out = main_vld_q;
  assign bus.sr_data_out  = main_dat_q;
  assign bus.sr_ready_out = ~skid_vld_q;
endmodule

// File: tb/tb_msg_fifo_stream_reg.sv
// Directed bench: vector tables for FIFO and stream register, plus
// hand sequences for fill/drain, full push+pop and mid-run reset.
module tb_msg_fifo_stream_reg;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  msg_fifo_stream_reg_if #(.DATA_WIDTH(26), .FIFO_WIDTH(32), .FIFO_DEPTH(256)) bus ();

  msg_fifo_stream_reg #(.DATA_WIDTH(26), .FIFO_WIDTH(32), .FIFO_DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr, rd, sclr;
    logic [31:0] d;
    logic [7:0]  usedw;
    logic        emp, ful;
    logic [31:0] q;
  } fvec_t;

  typedef struct {
    logic        vin;
    logic [25:0] din;
    logic        rin;
    logic        vout;
    logic [25:0] dout;
    logic        rout;
  } svec_t;

  fvec_t fv[18];
  svec_t sv[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wpat(input int i);
    return 32'hA5000000 | 32'(i);
  endfunction

  function automatic fvec_t fm(logic wr, logic rd, logic sc, logic [31:0] d,
                               logic [7:0] u, logic e, logic f, logic [31:0] q);
    fvec_t v;
    v.wr = wr; v.rd = rd; v.sclr = sc; v.d = d;
    v.usedw = u; v.emp = e; v.ful = f; v.q = q;
    return v;
  endfunction

  function automatic svec_t sm(logic vi, logic [25:0] di, logic ri,
                               logic vo, logic [25:0] dout, logic ro);
    svec_t v;
    v.vin = vi; v.din = di; v.rin = ri; v.vout = vo; v.dout = dout; v.rout = ro;
    return v;
  endfunction

  task automatic fifo_state(input string tag, input logic [7:0] u, input logic e,
                            input logic f, input logic [31:0] q);
    chk({tag, ".usedw"}, 32'(bus.fifo_usedw), 32'(u));
    chk({tag, ".empty"}, 32'(bus.fifo_empty), 32'(e));
    chk({tag, ".full"},  32'(bus.fifo_full),  32'(f));
    chk({tag, ".q"},     bus.fifo_q,          q);
  endtask

  task automatic fill256();
    bus.fifo_wrreq = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.fifo_data = wpat(i);
      tick();
      if (i == 254) begin
        chk("fill.usedw255", 32'(bus.fifo_usedw), 32'd255);
        chk("fill.notfull",  32'(bus.fifo_full),  32'd0);
      end
    end
    bus.fifo_wrreq = 1'b0;
  endtask

  initial begin
    // FIFO vectors: inputs for one edge, then expected registered outputs
    fv[0]  = fm(H, L, L, 32'h00524242, 8'd1, L, L, 32'h00524242);
    fv[1]  = fm(H, L, L, 32'h00010002, 8'd2, L, L, 32'h00524242);
    fv[2]  = fm(H, L, L, 32'h00020003, 8'd3, L, L, 32'h00524242);
    fv[3]  = fm(L, H, L, 32'h0,        8'd2, L, L, 32'h00010002);
    fv[4]  = fm(L, H, L, 32'h0,        8'd1, L, L, 32'h00020003);
    fv[5]  = fm(L, H, L, 32'h0,        8'd0, H, L, 32'h00020003);
    fv[6]  = fm(L, H, L, 32'h0,        8'd0, H, L, 32'h00020003);
    fv[7]  = fm(H, H, L, 32'h11111111, 8'd1, L, L, 32'h11111111);
    fv[8]  = fm(L, H, L, 32'h0,        8'd0, H, L, 32'h11111111);
    fv[9]  = fm(H, L, L, 32'hA0000001, 8'd1, L, L, 32'hA0000001);
    fv[10] = fm(H, L, L, 32'hA0000002, 8'd2, L, L, 32'hA0000001);
    fv[11] = fm(H, L, L, 32'hA0000003, 8'd3, L, L, 32'hA0000001);
    fv[12] = fm(H, L, L, 32'hA0000004, 8'd4, L, L, 32'hA0000001);
    fv[13] = fm(H, L, L, 32'hA0000005, 8'd5, L, L, 32'hA0000001);
    fv[14] = fm(H, L, H, 32'hBBBBBBBB, 8'd0, H, L, 32'hA0000001);
    fv[15] = fm(H, L, L, 32'hC0000001, 8'd1, L, L, 32'hC0000001);
    fv[16] = fm(H, H, L, 32'hC0000002, 8'd1, L, L, 32'hC0000002);
    fv[17] = fm(L, H, L, 32'h0,        8'd0, H, L, 32'hC0000002);

    // Stream vectors: back-to-back 1..10, idle, then a 3-cycle stall
    for (int k = 1; k <= 10; k++) sv[k-1] = sm(H, 26'(k), H, H, 26'(k), H);
    sv[10] = sm(L, 26'd0,  H, L, 26'd0,  H);
    sv[11] = sm(H, 26'd21, H, H, 26'd21, H);
    sv[12] = sm(H, 26'd22, L, H, 26'd21, L);
    sv[13] = sm(H, 26'd23, L, H, 26'd21, L);
    sv[14] = sm(H, 26'd23, L, H, 26'd21, L);
    sv[15] = sm(H, 26'd23, H, H, 26'd22, H);
    sv[16] = sm(H, 26'd23, H, H, 26'd23, H);
    sv[17] = sm(H, 26'd24, H, H, 26'd24, H);
    sv[18] = sm(L, 26'd0,  H, L, 26'd0,  H);

    bus.fifo_data = '0; bus.fifo_wrreq = 1'b0; bus.fifo_rdreq = 1'b0; bus.fifo_sclr = 1'b0;
    bus.sr_valid_in = 1'b0; bus.sr_data_in = '0; bus.sr_ready_in = 1'b0;

    #12;
    fifo_state("reset", 8'd0, H, L, 32'h0);
    chk("reset.vout", 32'(bus.sr_valid_out), 32'd0);
    chk("reset.rout", 32'(bus.sr_ready_out), 32'd1);
    chk("reset.dout", 32'(bus.sr_data_out),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      bus.fifo_wrreq = fv[i].wr;
      bus.fifo_rdreq = fv[i].rd;
      bus.fifo_sclr  = fv[i].sclr;
      bus.fifo_data  = fv[i].d;
      tick();
      fifo_state($sformatf("fvec%0d", i), fv[i].usedw, fv[i].emp, fv[i].ful, fv[i].q);
    end
    bus.fifo_wrreq = 1'b0; bus.fifo_rdreq = 1'b0; bus.fifo_sclr = 1'b0;

    // Fill to full, drop a write while full, drain in order
    fill256();
    fifo_state("full", 8'd0, L, H, wpat(0));
    bus.fifo_wrreq = 1'b1; bus.fifo_data = 32'hDEADBEEF;
    tick();
    bus.fifo_wrreq = 1'b0;
    fifo_state("fullwr", 8'd0, L, H, wpat(0));
    bus.fifo_rdreq = 1'b1;
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("drain%0d", i), bus.fifo_q, wpat(i));
      tick();
    end
    bus.fifo_rdreq = 1'b0;
    fifo_state("drained", 8'd0, H, L, wpat(255));

    // Push and pop together while full: both happen, count stays full
    fill256();
    bus.fifo_wrreq = 1'b1; bus.fifo_rdreq = 1'b1; bus.fifo_data = 32'h77777777;
    tick();
    bus.fifo_wrreq = 1'b0;
    fifo_state("fullrw", 8'd0, L, H, wpat(1));
    for (int i = 1; i < 256; i++) begin
      chk($sformatf("drain2_%0d", i), bus.fifo_q, wpat(i));
      tick();
    end
    chk("drain2_last", bus.fifo_q, 32'h77777777);
    tick();
    bus.fifo_rdreq = 1'b0;
    fifo_state("drained2", 8'd0, H, L, 32'h77777777);

    for (int i = 0; i < 19; i++) begin
      bus.sr_valid_in = sv[i].vin;
      bus.sr_data_in  = sv[i].din;
      bus.sr_ready_in = sv[i].rin;
      tick();
      chk($sformatf("svec%0d.vout", i), 32'(bus.sr_valid_out), 32'(sv[i].vout));
      chk($sformatf("svec%0d.rout", i), 32'(bus.sr_ready_out), 32'(sv[i].rout));
      if (sv[i].vout) chk($sformatf("svec%0d.dout", i), 32'(bus.sr_data_out), 32'(sv[i].dout));
    end

    // Reset in the middle of activity: both blocks hold data, skid full
    bus.fifo_wrreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.fifo_data = 32'h0BAD0000 | 32'(i);
      tick();
    end
    bus.fifo_wrreq = 1'b0;
    bus.sr_ready_in = 1'b0; bus.sr_valid_in = 1'b1; bus.sr_data_in = 26'd5;
    tick();
    bus.sr_data_in = 26'd6;
    tick();
    chk("prerst.rout", 32'(bus.sr_ready_out), 32'd0);
    bus.sr_valid_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    fifo_state("midrst", 8'd0, H, L, 32'h0);
    chk("midrst.vout", 32'(bus.sr_valid_out), 32'd0);
    chk("midrst.rout", 32'(bus.sr_ready_out), 32'd1);
    chk("midrst.dout", 32'(bus.sr_data_out),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.fifo_wrreq = 1'b1; bus.fifo_data = 32'h12345678;
    bus.sr_valid_in = 1'b1; bus.sr_data_in = 26'd9; bus.sr_ready_in = 1'b1;
    tick();
    bus.fifo_wrreq = 1'b0; bus.sr_valid_in = 1'b0;
    fifo_state("postrst", 8'd1, L, L, 32'h12345678);
    chk("postrst.vout", 32'(bus.sr_valid_out), 32'd1);
    chk("postrst.dout", 32'(bus.sr_data_out),  32'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
